// File: rtl/vec_stream_loader.sv
// Element-pair stream to packed-vector loader feeding dot_product.
// Optional early termination via in_last when VEC_ZERO_PAD_EN is defined.

module vec_lane_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         we,
    input  logic [W-1:0] d_a,
    input  logic [W-1:0] d_b,
    output logic [W-1:0] q_a,
    output logic [W-1:0] q_b
);
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q_a <= '0;
            q_b <= '0;
        end else if (we) begin
            q_a <= d_a;
            q_b <= d_b;
        end
    end
endmodule

module vec_stream_loader #(
    parameter int N  = 8,
    parameter int W  = 32,
    parameter int CW = $clog2(N+1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    input  logic          in_last,
    output logic [W*N-1:0] a_vec,
    output logic [W*N-1:0] b_vec,
    output logic          vec_valid,
    input  logic          vec_ready,
    output logic [CW-1:0] vec_len
);
    typedef enum logic {FILL, HOLD} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        idx, idx_nxt, len_nxt;
    logic                 accept, done, release_vec;
    logic [N-1:0][W-1:0]  a_lanes, b_lanes;

    assign accept      = in_valid && (state == FILL);
    assign release_vec = (state == HOLD) && vec_ready;

`ifdef VEC_ZERO_PAD_EN
    // Unwritten upper lanes are already zero from the last release or reset.
    assign done = accept && ((idx == CW'(N-1)) || in_last);
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
    assign done = accept && (idx == CW'(N-1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FILL;
            idx     <= '0;
            vec_len <= '0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            vec_len <= len_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        len_nxt   = vec_len;
        in_ready  = 1'b0;
        vec_valid = 1'b0;
        case (state)
            FILL: begin
                in_ready = 1'b1;
                if (done) begin
                    state_nxt = HOLD;
                    idx_nxt   = '0;
                    len_nxt   = idx + CW'(1);
                end else if (accept) begin
                    idx_nxt = idx + CW'(1);
                end
            end
            HOLD: begin
                vec_valid = 1'b1;
                if (vec_ready) begin
                    state_nxt = FILL;
                    len_nxt   = '0;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        vec_lane_reg #(.W(W)) u_lane (
            .clk (clk),
            .rst (rst),
            .clr (release_vec),
            .we  (accept && (idx == CW'(i))),
            .d_a (in_a),
            .d_b (in_b),
            .q_a (a_lanes[i]),
            .q_b (b_lanes[i])
        );
    end

    assign a_vec = a_lanes;
    assign b_vec = b_lanes;
endmodule

// File: tb/tb_vec_stream_loader.sv
// Directed bench for vec_stream_loader with a per-cycle behavioural model.
module tb_vec_stream_loader;
    localparam int N  = 8;
    localparam int W  = 32;
    localparam int CW = $clog2(N+1);
`ifdef VEC_ZERO_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_a = '0;
    logic [W-1:0]   in_b = '0;
    logic           in_last = 1'b0;
    logic [W*N-1:0] a_vec, b_vec;
    logic           vec_valid;
    logic           vec_ready = 1'b0;
    logic [CW-1:0]  vec_len;

    vec_stream_loader #(.N(N), .W(W), .CW(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .a_vec(a_vec),
        .b_vec(b_vec), .vec_valid(vec_valid), .vec_ready(vec_ready),
        .vec_len(vec_len)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [W*N-1:0] act, input logic [W*N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic longint unsigned dot(input logic [W*N-1:0] a, input logic [W*N-1:0] b);
        longint unsigned s = 0;
        for (int i = 0; i < N; i++) s += longint'(a[W*i +: W]) * longint'(b[W*i +: W]);
        return s;
    endfunction

    // Model: the vector is the list of accepted pairs since the last release.
    bit          m_live = 1'b0;
    bit          m_hold = 1'b0;
    int          m_cnt  = 0;
    int          m_len  = 0;
    int unsigned m_a[N];
    int unsigned m_b[N];

    initial for (int i = 0; i < N; i++) begin m_a[i] = 0; m_b[i] = 0; end

    always @(posedge clk) begin
        m_live <= 1'b1;
        if (rst) begin
            m_hold <= 1'b0; m_cnt <= 0; m_len <= 0;
            for (int i = 0; i < N; i++) begin m_a[i] <= 0; m_b[i] <= 0; end
        end else if (!m_hold) begin
            if (in_valid) begin
                m_a[m_cnt] <= in_a;
                m_b[m_cnt] <= in_b;
                if (m_cnt + 1 == N || (PAD && in_last)) begin
                    m_hold <= 1'b1; m_len <= m_cnt + 1; m_cnt <= 0;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end else if (vec_ready) begin
            m_hold <= 1'b0; m_len <= 0;
            for (int i = 0; i < N; i++) begin m_a[i] <= 0; m_b[i] <= 0; end
        end
    end

    always @(negedge clk) begin
        logic [W*N-1:0] ea, eb;
        if (m_live) begin
            for (int i = 0; i < N; i++) begin
                ea[W*i +: W] = m_a[i];
                eb[W*i +: W] = m_b[i];
            end
            check("m_in_ready",  in_ready,  !m_hold);
            check("m_vec_valid", vec_valid, m_hold);
            check("m_vec_len",   vec_len,   m_len);
            check("m_a_vec",     a_vec,     ea);
            check("m_b_vec",     b_vec,     eb);
        end
    end

    task automatic push(input int a, input int b, input bit last);
        in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic release_vec();
        vec_ready = 1'b1;
        @(posedge clk); #1;
        vec_ready = 1'b0;
    endtask

    logic [W*N-1:0] ref_a, ref_b;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_a_vec",     a_vec,     '0);
        check("rst_vec_valid", vec_valid, 0);
        check("rst_vec_len",   vec_len,   0);
        check("rst_in_ready",  in_ready,  1);

        // Full load
        for (int i = 0; i < N; i++) push(i + 1, 2 * (i + 1), 1'b0);
        check("full_vec_valid", vec_valid, 1);
        check("full_a_lane3",   a_vec[W*3 +: W], 4);
        check("full_b_lane7",   b_vec[W*7 +: W], 16);
        check("full_dot",       dot(a_vec, b_vec), 408);
        check("full_len",       vec_len, 8);
        ref_a = a_vec; ref_b = b_vec;

        // Backpressure with in_valid held high
        in_valid = 1'b1; in_a = 32'hDEAD; in_b = 32'hBEEF;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp_in_ready", in_ready, 0);
            check("bp_a_vec",    a_vec,    ref_a);
        end
        in_valid = 1'b0;
        release_vec();
        check("rel_a_vec",    a_vec,    '0);
        check("rel_b_vec",    b_vec,    '0);
        check("rel_in_ready", in_ready, 1);

        // Input gaps
        for (int i = 0; i < 4; i++) push(i + 1, 2 * (i + 1), 1'b0);
        in_a = 32'h1234; in_b = 32'h5678;
        repeat (3) begin @(posedge clk); #1; end
        check("gap_in_ready", in_ready, 1);
        for (int i = 4; i < N; i++) push(i + 1, 2 * (i + 1), 1'b0);
        check("gap_a_vec", a_vec, ref_a);
        check("gap_b_vec", b_vec, ref_b);
        check("gap_dot",   dot(a_vec, b_vec), 408);
        release_vec();

        // Reset mid-fill
        for (int i = 0; i < 5; i++) push(9, 9, 1'b0);
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        check("mrst_a_vec",     a_vec,     '0);
        check("mrst_vec_valid", vec_valid, 0);
        check("mrst_in_ready",  in_ready,  1);
        for (int i = 0; i < N; i++) push(1, 1, 1'b0);
        check("ones_dot", dot(a_vec, b_vec), 8);
        release_vec();

        // Early last
        push(1, 1, 1'b0); push(2, 2, 1'b0); push(3, 3, 1'b1);
`ifdef VEC_ZERO_PAD_EN
        check("last_vec_valid", vec_valid, 1);
        check("last_len",       vec_len,   3);
        check("last_upper",     a_vec[W*N-1:W*3], '0);
        check("last_dot",       dot(a_vec, b_vec), 14);
`else
        check("last_vec_valid", vec_valid, 0);
        check("last_in_ready",  in_ready,  1);
        for (int i = 3; i < N; i++) push(0, 0, 1'b0);
        check("last_len", vec_len, 8);
        check("last_dot", dot(a_vec, b_vec), 14);
`endif
        release_vec();

        // Back-to-back vectors
        for (int i = 0; i < N; i++) push(i + 1, 2 * (i + 1), 1'b0);
        release_vec();
        for (int i = 0; i < N; i++) push(3, 3, 1'b0);
        check("b2b_dot", dot(a_vec, b_vec), 72);
        check("b2b_len", vec_len, 8);
        release_vec();
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
